// File: rtl/decode_pkg.sv
// LC-3 decode definitions: opcodes, control encodings, decoded-control struct, decode function.
// Latency: decode_instr is purely combinational.
// Backpressure: none; the function is stateless.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  // Writeback source select
  localparam logic [1:0] W_ALU = 2'd0;
  localparam logic [1:0] W_PC  = 2'd1;
  localparam logic [1:0] W_MEM = 2'd2;

  // Address offset select for the PC/address adder
  localparam logic [1:0] PC1_ZERO = 2'b00;
  localparam logic [1:0] PC1_OFF6 = 2'b01;
  localparam logic [1:0] PC1_OFF9 = 2'b10;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  typedef struct packed {
    logic [5:0] E_control;   // {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    logic       Mem_Control; // indirect access
    logic [1:0] W_Control;   // writeback source
    logic       illegal;     // unsupported opcode
  } dec_ctrl_t;

  localparam int CTRL_W = $bits(dec_ctrl_t);

  // Unsupported opcodes leave every control at 0 and only raise illegal.
  function automatic dec_ctrl_t decode_instr(input logic [15:0] instr);
    dec_ctrl_t  d;
    logic [1:0] alu;
    logic [1:0] pc1;
    logic       pc2;
    logic       op2;
    d   = '0;
    alu = ALU_ADD;
    pc1 = PC1_ZERO;
    pc2 = 1'b0;
    op2 = 1'b0;
    case (opcode_t'(instr[15:12]))
      OP_ADD: op2 = ~instr[5];
      OP_AND: begin alu = ALU_AND; op2 = ~instr[5]; end
      OP_NOT: begin alu = ALU_NOT; op2 = 1'b1; end
      OP_BR:  begin pc1 = PC1_OFF9; pc2 = 1'b1; end
      OP_ST:  begin pc1 = PC1_OFF9; pc2 = 1'b1; end
      OP_LD:  begin pc1 = PC1_OFF9; pc2 = 1'b1; d.W_Control = W_MEM; end
      OP_LDI: begin pc1 = PC1_OFF9; pc2 = 1'b1; d.W_Control = W_MEM; d.Mem_Control = 1'b1; end
      OP_STI: begin pc1 = PC1_OFF9; pc2 = 1'b1; d.Mem_Control = 1'b1; end
      OP_LEA: begin pc1 = PC1_OFF9; pc2 = 1'b1; d.W_Control = W_PC; end
      OP_LDR: begin pc1 = PC1_OFF6; d.W_Control = W_MEM; end
      OP_STR: pc1 = PC1_OFF6;
      OP_JMP: pc1 = PC1_ZERO;
      default: d.illegal = 1'b1;
    endcase
    d.E_control = {alu, pc1, pc2, op2};
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
// Latency: wires only.
// Backpressure: in_ready/out_ready carry the valid/ready flow control.
interface decode_queue_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instr_dout;
  logic [DATA_W-1:0] npc_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] npc_out;
  logic [5:0]        E_control;
  logic              Mem_Control;
  logic [1:0]        W_Control;
  logic              illegal;
  logic [CNT_W-1:0]  count;

  // Environment side: fetch producer plus execute consumer
  modport master (
    output in_valid, instr_dout, npc_in, flush, out_ready,
    input  in_ready, out_valid, IR, npc_out, E_control, Mem_Control,
           W_Control, illegal, count
  );

  // Queue side
  modport slave (
    input  in_valid, instr_dout, npc_in, flush, out_ready,
    output in_ready, out_valid, IR, npc_out, E_control, Mem_Control,
           W_Control, illegal, count
  );
endinterface

// File: rtl/decode_fifo_mem.sv
// Storage array for decoded queue entries: one write port, one head read port.
// Latency: write lands at the clock edge; read is combinational from the registers.
// Backpressure: none; the controller only writes free slots.
module decode_fifo_mem #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming entry at the write pointer
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/decode_queue.sv
// LC-3 decode stage feeding a DEPTH-entry FIFO of decoded instructions.
// Latency: 1 cycle from accept to head; outputs come only from stored state.
// Backpressure: in_ready drops when full (no full bypass); head held while out_ready=0.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic          clock,
  input logic          reset,
  decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] npc;
    dec_ctrl_t         ctrl;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic             not_empty;
  entry_t           wr_entry;
  entry_t           head;

  assign not_empty     = (cnt != '0);
  assign bus.in_ready  = (cnt < FULL_CNT);
  assign bus.out_valid = not_empty;
  assign bus.count     = cnt;

  // Flush wins over both sides, so neither push nor pop is allowed to act
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = not_empty && bus.out_ready && !bus.flush;

  // Decode at enqueue so the head carries ready-made controls
  always_comb begin
    wr_entry      = '0;
    wr_entry.ir   = bus.instr_dout;
    wr_entry.npc  = bus.npc_in;
    wr_entry.ctrl = decode_instr(bus.instr_dout[15:0]);
  end

  decode_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Pointer and occupancy tracking; reset and flush both empty the queue
  always_ff @(posedge clock) begin
    if (!reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head fields, forced to zero while the queue is empty
  always_comb begin
    bus.IR          = '0;
    bus.npc_out     = '0;
    bus.E_control   = '0;
    bus.Mem_Control = 1'b0;
    bus.W_Control   = '0;
    bus.illegal     = 1'b0;
    if (not_empty) begin
      bus.IR          = head.ir;
      bus.npc_out     = head.npc;
      bus.E_control   = head.ctrl.E_control;
      bus.Mem_Control = head.ctrl.Mem_Control;
      bus.W_Control   = head.ctrl.W_Control;
      bus.illegal     = head.ctrl.illegal;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios with literal expectations plus random traffic.
// Latency: a queue-based reference predicts head contents one cycle after acceptance.
// Backpressure: random out_ready phases push the queue to full and empty.
module tb_decode_queue;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  bit   run_cmp;

  decode_queue_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dq ();

  decode_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference queue: each element is {IR, NPC}
  logic [31:0] mq [$];

  // Expected controls from the opcode tables: {E_control[5:0], Mem, W[1:0], illegal}
  function automatic logic [9:0] ref_ctrl(input logic [15:0] ir);
    logic [3:0] op;
    logic [1:0] alu, pc1, w;
    logic       pc2, op2, m, ill;
    op = ir[15:12];
    alu = 2'd0; pc1 = 2'd0; w = 2'd0; pc2 = 1'b0; op2 = 1'b0; m = 1'b0; ill = 1'b0;
    if (op == 4'd4 || op == 4'd8 || op == 4'd13 || op == 4'd15) ill = 1'b1;
    if (op == 4'd1) op2 = ~ir[5];
    if (op == 4'd5) begin alu = 2'd1; op2 = ~ir[5]; end
    if (op == 4'd9) begin alu = 2'd2; op2 = 1'b1; end
    if (op == 4'd0 || op == 4'd2 || op == 4'd3 || op == 4'd10 || op == 4'd11 || op == 4'd14) begin
      pc1 = 2'd2; pc2 = 1'b1;
    end
    if (op == 4'd6 || op == 4'd7) pc1 = 2'd1;
    if (op == 4'd2 || op == 4'd6 || op == 4'd10) w = 2'd2;
    if (op == 4'd14) w = 2'd1;
    if (op == 4'd10 || op == 4'd11) m = 1'b1;
    return {alu, pc1, pc2, op2, m, w, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference update on each edge from the same inputs the DUT samples
  always @(posedge clock) begin
    bit pu, po;
    if (!reset || dq.flush) begin
      mq.delete();
    end else begin
      pu = dq.in_valid && (mq.size() < DEPTH);
      po = (mq.size() != 0) && dq.out_ready;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({dq.instr_dout, dq.npc_in});
    end
  end

  // Mid-cycle comparison of every output against the reference
  int          exp_n;
  logic [31:0] hd;
  logic [9:0]  ec;
  always @(negedge clock) begin
    if (run_cmp) begin
      exp_n = mq.size();
      if (exp_n != 0) begin hd = mq[0]; ec = ref_ctrl(hd[31:16]); end
      else begin hd = '0; ec = '0; end
      chk("count",       32'(dq.count),       32'(exp_n));
      chk("out_valid",   32'(dq.out_valid),   32'(exp_n != 0));
      chk("in_ready",    32'(dq.in_ready),    32'(exp_n < DEPTH));
      chk("IR",          32'(dq.IR),          32'(hd[31:16]));
      chk("npc_out",     32'(dq.npc_out),     32'(hd[15:0]));
      chk("E_control",   32'(dq.E_control),   32'(ec[9:4]));
      chk("Mem_Control", 32'(dq.Mem_Control), 32'(ec[3]));
      chk("W_Control",   32'(dq.W_Control),   32'(ec[2:1]));
      chk("illegal",     32'(dq.illegal),     32'(ec[0]));
    end
  end

  task automatic push_one(input logic [15:0] ins, input logic [15:0] npc);
    dq.instr_dout = ins;
    dq.npc_in     = npc;
    step();
  endtask

  initial begin
    checks = 0; errors = 0; run_cmp = 1'b0;
    reset = 1'b0;
    dq.in_valid = 1'b0; dq.out_ready = 1'b0; dq.flush = 1'b0;
    dq.instr_dout = '0; dq.npc_in = '0;
    step(); step();
    chk("rst_count",     32'(dq.count),     32'd0);
    chk("rst_out_valid", 32'(dq.out_valid), 32'd0);
    chk("rst_in_ready",  32'(dq.in_ready),  32'd1);
    chk("rst_IR",        32'(dq.IR),        32'd0);
    reset = 1'b1;
    run_cmp = 1'b1;

    // ALU ops streamed with out_ready high
    dq.in_valid = 1'b1; dq.out_ready = 1'b1;
    push_one(16'h12A3, 16'h3000);
    chk("add_valid", 32'(dq.out_valid), 32'd1);
    chk("add_E",     32'(dq.E_control), 32'b000000);
    chk("add_W",     32'(dq.W_Control), 32'd0);
    push_one(16'h5263, 16'h3001);
    chk("and_E",     32'(dq.E_control), 32'b010000);
    chk("and_M",     32'(dq.Mem_Control), 32'd0);
    push_one(16'h927F, 16'h3002);
    chk("not_E",     32'(dq.E_control), 32'b100001);
    push_one(16'hA205, 16'h3001);
    chk("ldi_E",     32'(dq.E_control), 32'b001010);
    chk("ldi_W",     32'(dq.W_Control), 32'd2);
    chk("ldi_M",     32'(dq.Mem_Control), 32'd1);
    chk("ldi_npc",   32'(dq.npc_out), 32'h3001);
    push_one(16'h6242, 16'h3003);
    chk("ldr_E",     32'(dq.E_control), 32'b000100);
    chk("ldr_W",     32'(dq.W_Control), 32'd2);
    chk("ldr_M",     32'(dq.Mem_Control), 32'd0);
    push_one(16'hE205, 16'h3004);
    chk("lea_E",     32'(dq.E_control), 32'b001010);
    chk("lea_W",     32'(dq.W_Control), 32'd1);
    dq.in_valid = 1'b0;
    step();
    chk("drained_valid", 32'(dq.out_valid), 32'd0);

    // Fill to capacity with execute stalled
    dq.out_ready = 1'b0; dq.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) push_one(16'h1021 + 16'(i), 16'h3100 + 16'(i));
    chk("full_count",    32'(dq.count),    32'd4);
    chk("full_in_ready", 32'(dq.in_ready), 32'd0);
    dq.instr_dout = 16'h1025; dq.npc_in = 16'h3104;
    step(); step();
    chk("held_count", 32'(dq.count), 32'd4);
    chk("held_head",  32'(dq.IR),    32'h1021);
    dq.out_ready = 1'b1;
    step();
    chk("full_pop_count", 32'(dq.count), 32'd3);
    chk("full_pop_head",  32'(dq.IR),    32'h1022);
    step();
    chk("pushpop_count", 32'(dq.count), 32'd3);
    chk("pushpop_head",  32'(dq.IR),    32'h1023);

    // Flush with a competing enqueue
    dq.out_ready = 1'b0; dq.in_valid = 1'b1; dq.flush = 1'b1;
    dq.instr_dout = 16'hBEEF; dq.npc_in = 16'h3200;
    step();
    dq.flush = 1'b0; dq.in_valid = 1'b0;
    chk("flush_count",    32'(dq.count),     32'd0);
    chk("flush_valid",    32'(dq.out_valid), 32'd0);
    chk("flush_IR",       32'(dq.IR),        32'd0);
    chk("flush_in_ready", 32'(dq.in_ready),  32'd1);
    step();
    chk("flush_dropped",  32'(dq.count),     32'd0);

    // Illegal opcode kept in order
    dq.in_valid = 1'b1;
    push_one(16'hF025, 16'h4000);
    push_one(16'h1021, 16'h4001);
    dq.in_valid = 1'b0;
    chk("trap_ill", 32'(dq.illegal),   32'd1);
    chk("trap_E",   32'(dq.E_control), 32'd0);
    chk("trap_W",   32'(dq.W_Control), 32'd0);
    chk("trap_IR",  32'(dq.IR),        32'hF025);
    dq.out_ready = 1'b1;
    step();
    chk("after_trap_IR",  32'(dq.IR),      32'h1021);
    chk("after_trap_ill", 32'(dq.illegal), 32'd0);
    step();

    // Reset in the middle of traffic
    dq.out_ready = 1'b0; dq.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) push_one(16'h2000 + 16'(i), 16'h5000 + 16'(i));
    reset = 1'b0;
    step();
    reset = 1'b1; dq.in_valid = 1'b0;
    chk("mrst_count", 32'(dq.count),     32'd0);
    chk("mrst_valid", 32'(dq.out_valid), 32'd0);
    chk("mrst_IR",    32'(dq.IR),        32'd0);
    chk("mrst_E",     32'(dq.E_control), 32'd0);

    // Random traffic with alternating drain pressure
    for (int c = 0; c < 3000; c++) begin
      bit slow;
      slow = ((c / 150) % 2) == 1;
      dq.in_valid   = ($urandom_range(0, 3) != 0);
      dq.out_ready  = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      dq.instr_dout = 16'($urandom);
      dq.npc_in     = 16'($urandom);
      dq.flush      = ($urandom_range(0, 49) == 0);
      reset         = ($urandom_range(0, 149) != 0);
      step();
    end
    dq.flush = 1'b0; reset = 1'b1; dq.in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised LC-3 decode stage that sits between fetch and execute. Each accepted instruction is decoded into execute, memory and writeback controls, and the result is held in a DEPTH-entry FIFO with valid/ready handshakes on both sides. This lets fetch keep running while execute stalls. It adds flush, illegal-opcode flagging and occupancy reporting, which the single-register decode does not have.

Parameters:
DATA_W, 16, width of instruction, NPC and IR.
DEPTH, 4, FIFO entries; power of two, ≥2.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals count < DEPTH
instr_dout  in  DATA_W  instruction word
npc_in  in  DATA_W  PC+1 for the instruction
flush  in  1  synchronous discard of all entries
out_valid  out  1  head entry valid; equals count != 0
out_ready  in  1  execute consumes the head
IR  out  DATA_W  head instruction
npc_out  out  DATA_W  head NPC
E_control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
Mem_Control  out  1  indirect access (LDI/STI)
W_Control  out  2  writeback source select
illegal  out  1  head opcode is unsupported
count  out  CNT_W  current occupancy

Behaviour:
- Reset (reset==0 at a clock edge): pointers=0, count=0, out_valid=0, in_ready=1.
- Data outputs (IR, npc_out, E_control, Mem_Control, W_Control, illegal) read 0 whenever the queue is empty, including after reset.
- Decode is combinational on instr_dout. The decoded fields are stored with IR and NPC at enqueue. Outputs are driven from the head entry with no combinational path from input to output.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (1 cycle).
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- When full, in_ready=0 even if out_ready=1; there is no full bypass.
- Pointers wrap modulo DEPTH.
- Flush has priority over enqueue and dequeue in the same cycle. It clears the pointers and count; any enqueue that cycle is dropped. in_ready=1 on the next cycle.
- Reset mid-operation discards all entries, identical to flush.
- W_Control: 0 = ALU result (ADD/AND/NOT and all others); 1 = PC result (LEA); 2 = memory (LD/LDR/LDI).
- Mem_Control: 1 for LDI(1010) and STI(1011), else 0.
- alu_control: ADD 00, AND 01, NOT 10, else 00.
- pcselect1: 00 = zero (JMP), 01 = offset6 (LDR/STR), 10 = offset9 (BR/LD/ST/LDI/STI/LEA), 11 reserved.
- pcselect2: 1 = NPC base (BR/LD/ST/LDI/STI/LEA); 0 = BaseR (JMP/LDR/STR, ALU ops).
- op2select: 1 = register operand; ADD/AND give ~IR[5]; NOT gives 1; other opcodes give 0.
- Illegal opcodes 0100, 1000, 1101, 1111: illegal=1 and all controls 0. The entry is still queued and delivered in order.

Decomposition:
- Package decode_pkg holds: the opcode enum (4-bit); W_Control encodings W_ALU=0, W_PC=1, W_MEM=2; pcselect1 encodings; the packed struct dec_ctrl_t {E_control, Mem_Control, W_Control, illegal}; and the function decode_instr(instr) returning dec_ctrl_t.
- One sub-module, decode_fifo_mem: DEPTH x (2*DATA_W + 10) register array with write port and head read port.

Test Plan:
- ADD imm 0x12A3, then AND imm 0x5263, then NOT 0x927F, out_ready=1 -> out_valid follows each by 1 cycle. E_control = 000000, then 010000, then 100001. W=0 and M=0 for all three.
- LDI 0xA205 (npc_in=0x3001) -> E_control=001010, W=2, M=1, npc_out=0x3001. LDR 0x6242 -> E_control=000100, W=2, M=0. LEA 0xE205 -> E_control=001010, W=1.
- out_ready=0, push 5 instructions -> count reaches 4 and in_ready=0 from that point. The 5th instruction is held at the input, not accepted. Release out_ready -> entries drain in order.
- Full queue with in_valid=1 and out_ready=1 -> one dequeue only; count becomes 3. Next cycle, simultaneous push and pop keep count at 3, with pointer wrap exercised.
- Queue holding 3 entries, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, outputs 0, and the input word is dropped.
- TRAP 0xF025 -> illegal=1 and all controls 0, delivered in order. Assert reset mid-stream -> count=0 and all outputs 0 on the next cycle.
